// File: rtl/mips_cp0.sv
// MIPS coprocessor-0 register block: SR, Cause, EPC and PRID.
// Provides mtc0/mfc0 access, interrupt request generation and exception EPC capture.
module mips_cp0 #(
    parameter logic [31:0] PRID_VALUE = 32'h1800_0001,
    parameter logic [29:0] EPC_INIT   = 30'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] PC,
    input  logic [31:0] Din,
    input  logic [5:0]  HWInt,
    input  logic [1:0]  Sel,
    input  logic        Wen,
    input  logic        EXLSet,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [29:0] EPC,
    output logic [31:0] DOut
);

    logic [31:0] sr_q, sr_d;
    logic [5:0]  ip_q, ip_d;
    logic [29:0] epc_q, epc_d;

    logic        ie;
    logic        exl;
    logic [5:0]  im;

    assign ie  = sr_q[0];
    assign exl = sr_q[1];
    assign im  = sr_q[15:10];

    // Next state: software writes first, then exception entry/return overrides EXL and EPC.
    always_comb begin
        sr_d  = sr_q;
        epc_d = epc_q;
        ip_d  = HWInt;
        if (Wen && (Sel == 2'd0)) begin
            sr_d = Din;
        end
        if (Wen && (Sel == 2'd2)) begin
            epc_d = Din[31:2];
        end
        if (EXLSet) begin
            sr_d[1] = 1'b1;
            epc_d   = PC;
        end else if (EXLClr) begin
            sr_d[1] = 1'b0;
        end
    end

    // State registers with asynchronous reset to architectural reset values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= 32'h0000_0001;
            ip_q  <= 6'b0;
            epc_q <= EPC_INIT;
        end else begin
            sr_q  <= sr_d;
            ip_q  <= ip_d;
            epc_q <= epc_d;
        end
    end

    // Combinational mfc0 read mux.
    always_comb begin
        DOut = 32'b0;
        unique case (Sel)
            2'd0: DOut = sr_q;
            2'd1: DOut = {16'b0, ip_q, 10'b0};
            2'd2: DOut = {epc_q, 2'b00};
            2'd3: DOut = PRID_VALUE;
        endcase
    end

    assign IntReq = (|(ip_q & im)) & ie & ~exl;
    assign EPC    = epc_q;

endmodule

// File: tb/tb_mips_cp0.sv
// Self-checking bench for mips_cp0.
// Expected values are queued as stimulus is applied and compared after the edge.
`timescale 1ns/1ps
module tb_mips_cp0;

    localparam logic [31:0] PRID = 32'h1800_0001;
    localparam logic [29:0] EINI = 30'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] PC;
    logic [31:0] Din;
    logic [5:0]  HWInt;
    logic [1:0]  Sel;
    logic        Wen;
    logic        EXLSet;
    logic        EXLClr;
    logic        IntReq;
    logic [29:0] EPC;
    logic [31:0] DOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [1:0]  sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    mips_cp0 #(.PRID_VALUE(PRID), .EPC_INIT(EINI)) dut (
        .clk(clk), .reset(reset), .PC(PC), .Din(Din), .HWInt(HWInt),
        .Sel(Sel), .Wen(Wen), .EXLSet(EXLSet), .EXLClr(EXLClr),
        .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // kind 0: DOut at sel; 1: IntReq; 2: EPC port
    task automatic push(input string tag, input int kind,
                        input logic [1:0] sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.kind = kind;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == 0) begin
                Sel = e.sel;
                #0.2;
                chk(e.tag, DOut, e.val);
            end else if (e.kind == 1) begin
                #0.2;
                chk(e.tag, {31'b0, IntReq}, e.val);
            end else begin
                #0.2;
                chk(e.tag, {2'b0, EPC}, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        Wen = 1'b0;
        EXLSet = 1'b0;
        EXLClr = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        PC = '0;
        Din = '0;
        HWInt = '0;
        Sel = '0;
        Wen = 1'b0;
        EXLSet = 1'b0;
        EXLClr = 1'b0;
        #3;
        push("rst_sr", 0, 2'd0, 32'h0000_0001);
        push("rst_cause", 0, 2'd1, 32'h0);
        push("rst_epc", 0, 2'd2, {EINI, 2'b00});
        push("rst_prid", 0, 2'd3, PRID);
        push("rst_epc_port", 2, 2'd0, {2'b0, EINI});
        push("rst_intreq", 1, 2'd0, 32'd0);
        drain();
        @(negedge clk);
        reset = 1'b0;

        // readback
        Wen = 1'b1; Sel = 2'd0; Din = 32'h1234_5678;
        push("sr_write", 0, 2'd0, 32'h1234_5678);
        tick(); drain();
        Din = 32'hFFFF_FFFF;
        push("sr_hold", 0, 2'd0, 32'h1234_5678);
        push("cause_zero", 0, 2'd1, 32'h0);
        push("epc_init", 0, 2'd2, {EINI, 2'b00});
        push("prid", 0, 2'd3, PRID);
        tick(); drain();

        // exception entry / return after reset
        reset = 1'b1; #1; reset = 1'b0;
        EXLSet = 1'b1; PC = 30'h1234_5678;
        push("exl_set_sr", 0, 2'd0, 32'h3);
        push("exl_set_epc", 2, 2'd0, {2'b0, 30'h1234_5678});
        push("exl_set_epc_rd", 0, 2'd2, {30'h1234_5678, 2'b00});
        tick(); drain();
        EXLClr = 1'b1;
        push("exl_clr_sr", 0, 2'd0, 32'h1);
        push("exl_clr_epc", 2, 2'd0, {2'b0, 30'h1234_5678});
        tick(); drain();

        // interrupt sampling
        HWInt = 6'b101011;
        push("cause_ip", 0, 2'd1, 32'h0000_AC00);
        tick(); drain();

        // masking
        Wen = 1'b1; Sel = 2'd0; Din = {16'b0, 6'b010100, 8'b0, 1'b0, 1'b1};
        push("mask_sr", 0, 2'd0, 32'h0000_5001);
        push("masked_irq", 1, 2'd0, 32'd0);
        tick(); drain();
        HWInt = 6'b111011;
        push("irq_hi", 1, 2'd0, 32'd1);
        push("irq_epc", 2, 2'd0, {2'b0, 30'h1234_5678});
        tick(); drain();
        EXLSet = 1'b1; PC = 30'h3478_ABCD;
        push("exl_irq", 1, 2'd0, 32'd0);
        push("exl_epc", 2, 2'd0, {2'b0, 30'h3478_ABCD});
        push("exl_sr", 0, 2'd0, 32'h0000_5003);
        tick(); drain();
        EXLClr = 1'b1;
        push("eret_irq", 1, 2'd0, 32'd1);
        push("eret_epc", 2, 2'd0, {2'b0, 30'h3478_ABCD});
        tick(); drain();
        Wen = 1'b1; Sel = 2'd0; Din = 32'h0000_5000;
        push("ie_off_irq", 1, 2'd0, 32'd0);
        tick(); drain();

        // both EXL controls
        EXLSet = 1'b1; EXLClr = 1'b1; PC = 30'h0000_0040;
        push("both_sr", 0, 2'd0, 32'h0000_5002);
        push("both_epc", 2, 2'd0, {2'b0, 30'h0000_0040});
        tick(); drain();

        // mtc0 to EPC, then capture priority and SR EXL override
        Wen = 1'b1; Sel = 2'd2; Din = 32'hCAFE_F00F;
        push("epc_mtc0", 0, 2'd2, 32'hCAFE_F00C);
        push("epc_mtc0_port", 2, 2'd0, {2'b0, 30'h32BF_BC03});
        tick(); drain();
        Wen = 1'b1; Sel = 2'd2; Din = 32'h1111_1110;
        EXLSet = 1'b1; PC = 30'h0000_0055;
        push("epc_prio", 2, 2'd0, {2'b0, 30'h0000_0055});
        tick(); drain();
        Wen = 1'b1; Sel = 2'd0; Din = 32'h0000_0000; EXLSet = 1'b1;
        push("sr_exl_ovr", 0, 2'd0, 32'h0000_0002);
        tick(); drain();
        Wen = 1'b1; Sel = 2'd0; Din = 32'hFFFF_FFFF; EXLClr = 1'b1;
        push("sr_exl_clr_ovr", 0, 2'd0, 32'hFFFF_FFFD);
        tick(); drain();
        Wen = 1'b1; Sel = 2'd1; Din = 32'hFFFF_FFFF; HWInt = 6'b000001;
        push("cause_ro", 0, 2'd1, 32'h0000_0400);
        tick(); drain();

        // reset mid-operation
        Wen = 1'b1; Sel = 2'd0; Din = 32'hFFFF_FFFF; EXLSet = 1'b1;
        PC = 30'h0ABC_DEF0;
        @(negedge clk);
        reset = 1'b1;
        push("mid_rst_sr", 0, 2'd0, 32'h0000_0001);
        push("mid_rst_cause", 0, 2'd1, 32'h0);
        push("mid_rst_epc", 2, 2'd0, {2'b0, EINI});
        drain();
        Sel = 2'd0;
        @(posedge clk);
        #1;
        push("held_rst_sr", 0, 2'd0, 32'h0000_0001);
        push("held_rst_epc", 2, 2'd0, {2'b0, EINI});
        push("held_rst_irq", 1, 2'd0, 32'd0);
        drain();
        Wen = 1'b0; EXLSet = 1'b0;
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
